// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Purpose : bundles the two bus-style connections of the instruction memory
//           loader: the byte stream from the serial receiver (valid/ready)
//           and the instruction RAM write port.
// Signals :
//   rx_data   [7:0]        incoming byte
//   rx_valid               rx_data valid
//   rx_ready               loader can accept a byte this cycle
//   mem_we                 instruction RAM write enable (one cycle per word)
//   mem_addr  [ADDR_W-1:0] word address for the write
//   mem_wdata [15:0]       instruction word to write
// Modports:
//   master : environment side (byte source + RAM)
//   slave  : loader side
// ---------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_W = 9
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Purpose : writer side of the instruction memory. Receives a program image
//           as a big-endian byte stream (LEN_HI, LEN_LO, 2N data bytes and,
//           when enabled, one checksum byte) and writes it word by word into
//           the instruction RAM, holding the CPU off while loading.
// Ports   :
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   i_start          single-cycle pulse, begins a load session
//   bus (slave)      rx_data/rx_valid/rx_ready byte stream and
//                    mem_we/mem_addr/mem_wdata RAM write port
//   o_cpu_hold       CPU held in reset / PC frozen
//   o_busy           session in progress
//   o_done           image loaded successfully (level)
//   o_err            session failed (level)
//   o_words_written  words written in the current session
// Build option:
//   IMEM_LOADER_CHECKSUM_EN  adds an 8-bit checksum byte after the data;
//                            the data bytes plus checksum must sum to 0 mod 256.
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  imem_loader_if.slave      bus,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W:0]   o_words_written
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LEN_HI  = 4'd1;
  localparam logic [3:0] S_LEN_LO  = 4'd2;
  localparam logic [3:0] S_DATA_HI = 4'd3;
  localparam logic [3:0] S_DATA_LO = 4'd4;
  localparam logic [3:0] S_WRITE   = 4'd5;
  localparam logic [3:0] S_DONE    = 4'd6;
  localparam logic [3:0] S_ERR     = 4'd7;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [3:0] S_CSUM    = 4'd8;
`endif

  localparam logic [16:0]       DEPTH_LEN = 17'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  logic [3:0]        r_state;
  logic [7:0]        r_lenHi;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic [ADDR_W:0]   r_wordsWritten;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_sum;
  logic [7:0]        w_csumTotal;
`endif

  logic              w_rxReady;
  logic              w_accept;
  logic              w_sessionStart;
  logic [15:0]       w_len;
  logic              w_lenBad;
  logic [ADDR_W:0]   w_nextCount;
  logic              w_lastWord;

  // Ready is purely a function of the state, so it never depends on rx_valid
  // and the source can rely on it being stable for the whole cycle.
  assign w_rxReady = (r_state == S_LEN_HI)  || (r_state == S_LEN_LO) ||
                     (r_state == S_DATA_HI) || (r_state == S_DATA_LO)
`ifdef IMEM_LOADER_CHECKSUM_EN
                     || (r_state == S_CSUM)
`endif
                     ;
  assign w_accept = bus.rx_valid && w_rxReady;

  // A session may be (re)started only from an idle or finished state;
  // start pulses during a session are ignored.
  assign w_sessionStart = i_start &&
                          ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

  // The length is checked against the live low byte so the decision is made
  // on the same edge that accepts LEN_LO. A valid length always fits in
  // ADDR_W+1 bits because DEPTH <= 2^ADDR_W.
  assign w_len       = {r_lenHi, bus.rx_data};
  assign w_lenBad    = (w_len == 16'd0) || ({1'b0, w_len} > DEPTH_LEN);
  assign w_nextCount = r_wordsWritten + CNT_ONE;
  assign w_lastWord  = (w_nextCount == r_len);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign w_csumTotal = r_sum + bus.rx_data;
`endif

  // Status outputs derive from the state alone. The CPU stays held after an
  // error so a partially loaded image never runs.
  assign o_busy          = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
  assign o_done          = (r_state == S_DONE);
  assign o_err           = (r_state == S_ERR);
  assign o_cpu_hold      = o_busy || o_err;
  assign o_words_written = r_wordsWritten;

  assign bus.rx_ready  = w_rxReady;
  assign bus.mem_we    = (r_state == S_WRITE);
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

  // Main session FSM. The high byte of each word lands in the upper half of
  // the write-data register and the low byte in the lower half, so the
  // register already holds {hi,lo} during the WRITE cycle. The address
  // stops at the last RAM word instead of wrapping after a full-depth image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_lenHi        <= 8'd0;
      r_len          <= '0;
      r_addr         <= '0;
      r_wdata        <= 16'd0;
      r_wordsWritten <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum          <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_sessionStart) begin
            r_state        <= S_LEN_HI;
            r_addr         <= '0;
            r_wordsWritten <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum          <= 8'd0;
`endif
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_lenHi <= bus.rx_data;
            r_state <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len   <= w_len[ADDR_W:0];
            r_state <= w_lenBad ? S_ERR : S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (w_accept) begin
            r_wdata[15:8] <= bus.rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum         <= w_csumTotal;
`endif
            r_state       <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (w_accept) begin
            r_wdata[7:0] <= bus.rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum        <= w_csumTotal;
`endif
            r_state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_wordsWritten <= w_nextCount;
          if (r_addr != LAST_ADDR) begin
            r_addr <= r_addr + ADDR_ONE;
          end
          if (!w_lastWord) begin
            r_state <= S_DATA_HI;
          end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state <= S_CSUM;
`else
            r_state <= S_DONE;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_accept) begin
            r_state <= (w_csumTotal == 8'd0) ? S_DONE : S_ERR;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Purpose : self-checking bench for imem_loader. A frame-level model turns a
//           length and data bytes into the list of expected RAM writes and
//           the expected session outcome; a monitor compares every write
//           the loader makes against that list. Randomized frames, valid
//           patterns and stray start pulses are mixed with fixed frames whose
//           results are pinned by literal values.
// Build option:
//   IMEM_LOADER_CHECKSUM_EN  frames carry a checksum byte; the model follows.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_start;
  logic              o_cpu_hold;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic [ADDR_W:0]   o_words_written;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (i_start),
    .bus             (bus),
    .o_cpu_hold      (o_cpu_hold),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_err           (o_err),
    .o_words_written (o_words_written)
  );

  always #5 clk = ~clk;

  int                checkCount = 0;
  int                failCount  = 0;
  int                writeCount = 0;
  logic [7:0]        dataBytes[$];
  logic [7:0]        frameBytes[$];
  logic [ADDR_W-1:0] expAddr[$];
  logic [15:0]       expData[$];
  logic [15:0]       ramImage[DEPTH];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rx_ready"}, bus.rx_ready, 0);
    checkOutput({tag, "_mem_we"}, bus.mem_we, 0);
    checkOutput({tag, "_mem_addr"}, bus.mem_addr, 0);
    checkOutput({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    checkOutput({tag, "_cpu_hold"}, o_cpu_hold, 0);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_done"}, o_done, 0);
    checkOutput({tag, "_err"}, o_err, 0);
    checkOutput({tag, "_words"}, o_words_written, 0);
  endtask

  // Every RAM write must be the next one the model predicted, and the loader
  // must not offer to take a byte while it is writing.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_we) begin
        writeCount++;
        ramImage[bus.mem_addr] = bus.mem_wdata;
        checkOutput("write_expected", expAddr.size() > 0, 1);
        if (expAddr.size() > 0) begin
          checkOutput("write_addr", bus.mem_addr, expAddr.pop_front());
          checkOutput("write_data", bus.mem_wdata, expData.pop_front());
        end
        checkOutput("ready_low_in_write", bus.rx_ready, 0);
      end
      if (o_busy) begin
        checkOutput("hold_while_busy", o_cpu_hold, 1);
      end
    end
  end

  task automatic startSession();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    checkOutput("start_busy", o_busy, 1);
    checkOutput("start_hold", o_cpu_hold, 1);
    checkOutput("start_done_clr", o_done, 0);
    checkOutput("start_err_clr", o_err, 0);
    checkOutput("start_words_clr", o_words_written, 0);
    checkOutput("start_ready", bus.rx_ready, 1);
  endtask

  // Presents frameBytes in order. mode 0: valid always high; 1: valid
  // toggles every cycle; 2: random valid plus occasional stray start pulses.
  // rx_ready depends only on the loader state, so whether the byte on the
  // bus is taken at the next rising edge is known at the falling edge.
  task automatic sendFrame(input int mode);
    int idx;
    int cycles;
    int budget;
    idx = 0;
    cycles = 0;
    budget = 10 * frameBytes.size() + 50;
    while (idx < frameBytes.size() && cycles < budget) begin
      @(negedge clk);
      bus.rx_data = frameBytes[idx];
      case (mode)
        0:       bus.rx_valid = 1'b1;
        1:       bus.rx_valid = (cycles[0] == 1'b0);
        default: bus.rx_valid = ($urandom_range(99) < 60);
      endcase
      i_start = (mode == 2) && ($urandom_range(19) == 0);
      if (bus.rx_valid && bus.rx_ready) idx++;
      cycles++;
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    i_start = 1'b0;
    bus.rx_data = 8'($urandom);
    checkOutput("frame_consumed", idx, frameBytes.size());
  endtask

  // Builds the frame for length n from dataBytes, predicts the writes and
  // the outcome, runs one session and checks the final status.
  task automatic applyStimulus(input int n, input int mode, input bit csumOverride,
                               input logic [7:0] csumByte);
    bit         lenOk;
    bit         expDone;
    logic [7:0] sum;
    logic [7:0] csum;
    int         writesBefore;
    int         waitCycles;
    int         expLatency;
    lenOk = (n >= 1) && (n <= DEPTH);
    expAddr.delete();
    expData.delete();
    frameBytes.delete();
    frameBytes.push_back(n[15:8]);
    frameBytes.push_back(n[7:0]);
    sum = 8'd0;
    if (lenOk) begin
      for (int w = 0; w < n; w++) begin
        expAddr.push_back(w[ADDR_W-1:0]);
        expData.push_back({dataBytes[2*w], dataBytes[2*w+1]});
        frameBytes.push_back(dataBytes[2*w]);
        frameBytes.push_back(dataBytes[2*w+1]);
        sum = sum + dataBytes[2*w] + dataBytes[2*w+1];
      end
    end
    expDone = lenOk;
    csum = csumOverride ? csumByte : 8'(8'd0 - sum);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (lenOk) begin
      frameBytes.push_back(csum);
      expDone = (8'(sum + csum) == 8'd0);
    end
    expLatency = 0;
`else
    expLatency = (lenOk && csum == csum) ? 1 : 0;
`endif
    writesBefore = writeCount;
    startSession();
    sendFrame(mode);
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (lenOk) checkOutput("latency_we", bus.mem_we, 1);
`endif
    waitCycles = 0;
    while (!(o_done || o_err) && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("end_latency", waitCycles, expLatency);
    checkOutput("end_done", o_done, expDone);
    checkOutput("end_err", o_err, !expDone);
    checkOutput("end_hold", o_cpu_hold, !expDone);
    checkOutput("end_busy", o_busy, 0);
    checkOutput("end_ready", bus.rx_ready, 0);
    checkOutput("end_words", o_words_written, lenOk ? n : 0);
    checkOutput("end_write_count", writeCount - writesBefore, lenOk ? n : 0);
    checkOutput("end_missing_writes", expAddr.size(), 0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int wc;
    rst_n = 1'b0;
    i_start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'd0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    // Start with no bytes: the loader must wait with ready high.
    startSession();
    repeat (20) @(negedge clk);
    checkOutput("wait_busy", o_busy, 1);
    checkOutput("wait_hold", o_cpu_hold, 1);
    checkOutput("wait_ready", bus.rx_ready, 1);
    checkOutput("wait_no_write", writeCount, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Normal two-word load, then the same stream with toggling valid.
    for (int pass = 0; pass < 2; pass++) begin
      ramImage[0] = 16'h0000;
      ramImage[1] = 16'h0000;
      dataBytes = '{8'hF0, 8'h51, 8'h80, 8'hE0};
      wc = writeCount;
      applyStimulus(2, pass, 1'b0, 8'h00);
      checkOutput("lit_addr0", ramImage[0], 16'hF051);
      checkOutput("lit_addr1", ramImage[1], 16'h80E0);
      checkOutput("lit_we_cycles", writeCount - wc, 2);
      checkOutput("lit_words", o_words_written, 2);
      checkOutput("lit_done", o_done, 1);
      checkOutput("lit_hold", o_cpu_hold, 0);
    end

    // Bad lengths: zero and DEPTH+1.
    dataBytes.delete();
    wc = writeCount;
    applyStimulus(0, 0, 1'b0, 8'h00);
    checkOutput("lit_len0_err", o_err, 1);
    checkOutput("lit_len0_hold", o_cpu_hold, 1);
    applyStimulus(16'h0201, 1, 1'b0, 8'h00);
    checkOutput("lit_len513_err", o_err, 1);
    checkOutput("lit_badlen_no_write", writeCount - wc, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    dataBytes = '{8'h12, 8'h34};
    applyStimulus(1, 0, 1'b1, 8'hBA);
    checkOutput("lit_csum_ok_done", o_done, 1);
    ramImage[0] = 16'h0000;
    applyStimulus(1, 0, 1'b1, 8'hBB);
    checkOutput("lit_csum_bad_err", o_err, 1);
    checkOutput("lit_csum_bad_kept", ramImage[0], 16'h1234);
`endif

    // Reset after three of six data bytes: one word is already written.
    startSession();
    frameBytes = '{8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3};
    expAddr.delete();
    expData.delete();
    expAddr.push_back('0);
    expData.push_back(16'hA1B2);
    sendFrame(0);
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    checkOutput("midreset_word0", expAddr.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dataBytes = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
    applyStimulus(3, 0, 1'b0, 8'h00);
    checkOutput("lit_after_reset_done", o_done, 1);

    // Full-depth image: last write lands on the last RAM word.
    dataBytes.delete();
    for (int i = 0; i < 2 * DEPTH; i++) dataBytes.push_back(8'($urandom));
    applyStimulus(DEPTH, 0, 1'b0, 8'h00);
    checkOutput("lit_full_words", o_words_written, DEPTH);

    // Randomized sessions.
    for (int s = 0; s < 30; s++) begin
      case ($urandom_range(9))
        0:       n = 0;
        1:       n = DEPTH + 1 + int'($urandom_range(1000));
        default: n = int'($urandom_range(12, 1));
      endcase
      dataBytes.delete();
      for (int i = 0; i < 2 * n && n <= DEPTH; i++) dataBytes.push_back(8'($urandom));
      applyStimulus(n, int'($urandom_range(2)), 1'($urandom_range(1)), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
